muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 unsigned multiply/divide unit for the Execute stage
// Shares one accumulator/shift pair between shift-add multiply and restoring divide.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             x_stall,
  input  logic             flush,
  output logic             alu_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               accept;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   iter_acc;
  logic [WIDTH-1:0]   iter_lo;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign last_iter = (state_q == S_BUSY) && (cnt_q == '0);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything except reset
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start)      state_d = S_BUSY;
        S_BUSY: if (cnt_q == '0) state_d = S_DONE;
        S_DONE: if (!x_stall)   state_d = S_IDLE;
        default:                state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    alu_ready    = 1'b1;
    result_valid = 1'b0;
    case (state_q)
      S_IDLE: alu_ready = !(start && !flush);
      S_BUSY: alu_ready = 1'b0;
      S_DONE: result_valid = !flush;
      default: alu_ready = 1'b1;
    endcase
  end

  // Multiply: product is {acc, lo}; lo starts as the multiplier and drains out LSB-first.
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);

  // Divide: acc is the remainder, lo shifts the dividend out MSB-first and the quotient in.
  // The borrow bit of the (WIDTH+1)-bit trial subtraction decides the quotient bit.
  assign div_shift = {acc_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = !div_diff[WIDTH];

  always_comb begin
    iter_acc = mul_sum[WIDTH:1];
    iter_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (op_q[1]) begin
      iter_acc = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      iter_lo  = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  // Datapath next-state; an aborted operation never reaches the result register
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    if (accept) begin
      cnt_d = CNT_W'(WIDTH - 1);
      op_d  = op;
      acc_d = '0;
      lo_d  = src_a;
      b_d   = src_b;
    end else if ((state_q == S_BUSY) && !flush) begin
      acc_d = iter_acc;
      lo_d  = iter_lo;
      if (last_iter) begin
        // MULHU and REMU take the upper half, MUL and DIVU the lower half
        result_d = op_q[0] ? iter_acc : iter_lo;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
// Randomized and directed operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int LAT_LOW = 33;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          x_stall = 1'b0;
  logic          flush = 1'b0;
  logic          alu_ready;
  logic [W-1:0]  result;
  logic          result_valid;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] last_res = '0;

  muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .x_stall      (x_stall),
    .flush        (flush),
    .alu_ready    (alu_ready),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents an op in the current cycle (C0) and returns in the first cycle alu_ready is high.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int low);
    start = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    #1;
    low = 0;
    while (alu_ready === 1'b0 && low < 40) begin
      low++;
      tick();
      src_a = $urandom;
      src_b = $urandom;
      op = 2'($urandom);
      #1;
    end
  endtask

  // Runs one op without stall; samples at the ready cycle and returns one cycle later.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int low, output logic [W-1:0] res, output logic vld, output logic rdy);
    launch(o, a, b, low);
    res = result;
    vld = result_valid;
    rdy = alu_ready;
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", alu_ready); end
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    checks++;
    if (result !== '0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    last_res = '0;
  endtask

  task automatic test_mul();
    int low; logic [W-1:0] res; logic vld, rdy;
    logic [1:0] ops [3] = '{2'd0, 2'd1, 2'd0};
    logic [W-1:0] as [3] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] bs [3] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] exp_r [3] = '{32'd42, 32'hFFFF_FFFE, 32'h0000_0001};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], low, res, vld, rdy);
      last_res = exp_r[i];
      checks++;
      if (low !== LAT_LOW) begin failures++; $display("FAIL mul_busy_cycles[%0d]: got %0d expected %0d", i, low, LAT_LOW); end
      checks++;
      if (vld !== 1'b1 || rdy !== 1'b1) begin failures++; $display("FAIL mul_done_flags[%0d]: got valid=%b ready=%b expected 1/1", i, vld, rdy); end
      checks++;
      if (res !== exp_r[i]) begin failures++; $display("FAIL mul_result[%0d]: got %h expected %h", i, res, exp_r[i]); end
      checks++;
      if (result_valid !== 1'b0 || alu_ready !== 1'b1) begin failures++; $display("FAIL mul_idle_after[%0d]: got valid=%b ready=%b expected 0/1", i, result_valid, alu_ready); end
    end
  endtask

  task automatic test_divu();
    int low; logic [W-1:0] res; logic vld, rdy;
    logic [1:0] ops [4] = '{2'd2, 2'd3, 2'd2, 2'd3};
    logic [W-1:0] as [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [W-1:0] bs [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] exp_r [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], low, res, vld, rdy);
      last_res = exp_r[i];
      checks++;
      if (low !== LAT_LOW) begin failures++; $display("FAIL div_busy_cycles[%0d]: got %0d expected %0d", i, low, LAT_LOW); end
      checks++;
      if (vld !== 1'b1 || res !== exp_r[i]) begin failures++; $display("FAIL div_result[%0d]: got valid=%b result=%h expected 1/%h", i, vld, res, exp_r[i]); end
    end
  endtask

  task automatic test_flush();
    logic seen_valid;
    start = 1'b1; op = 2'd2; src_a = 32'd100; src_b = 32'd7;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || result_valid !== 1'b0) begin failures++; $display("FAIL flush_idle: got ready=%b valid=%b expected 1/0", alu_ready, result_valid); end
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid === 1'b1) seen_valid = 1'b1;
      tick();
    end
    checks++;
    if (seen_valid !== 1'b0) begin failures++; $display("FAIL flush_no_valid: got %b expected 0", seen_valid); end
    checks++;
    if (result !== last_res) begin failures++; $display("FAIL flush_result_kept: got %h expected %h", result, last_res); end
    start = 1'b1; flush = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd3;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin failures++; $display("FAIL flush_start_ready: got %b expected 1", alu_ready); end
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || result_valid !== 1'b0) begin failures++; $display("FAIL flush_start_no_accept: got ready=%b valid=%b expected 1/0", alu_ready, result_valid); end
  endtask

  task automatic test_stall_hold();
    int low;
    int held;
    launch(2'd0, 32'd3, 32'd5, low);
    x_stall = 1'b1;
    checks++;
    if (low !== LAT_LOW) begin failures++; $display("FAIL stall_busy_cycles: got %0d expected %0d", low, LAT_LOW); end
    held = 0;
    for (int i = 0; i < 3; i++) begin
      if (result_valid === 1'b1 && result === 32'd15 && alu_ready === 1'b1) held++;
      tick();
    end
    x_stall = 1'b0;
    start = 1'b0;
    #1;
    if (result_valid === 1'b1 && result === 32'd15) held++;
    checks++;
    if (held !== 4) begin failures++; $display("FAIL stall_hold: got %0d held cycles expected 4", held); end
    tick();
    checks++;
    if (result_valid !== 1'b0 || alu_ready !== 1'b1) begin failures++; $display("FAIL stall_release_idle: got valid=%b ready=%b expected 0/1", result_valid, alu_ready); end
    launch(2'd2, 32'd9, 32'd3, low);
    checks++;
    if (low !== LAT_LOW || result_valid !== 1'b1 || result !== 32'd3) begin
      failures++; $display("FAIL stall_next_divu: got low=%0d valid=%b result=%h expected %0d/1/3", low, result_valid, result, LAT_LOW);
    end
    start = 1'b0;
    tick();
    last_res = 32'd3;
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; op = 2'd0; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (result !== '0 || result_valid !== 1'b0 || alu_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid_op: got result=%h valid=%b ready=%b expected 0/0/1", result, result_valid, alu_ready);
    end
    last_res = '0;
  endtask

  task automatic test_back_to_back();
    int low; logic [W-1:0] res; logic vld, rdy;
    logic [1:0] o; logic [W-1:0] a, b, exp_r;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      exp_r = model(o, a, b);
      run_op(o, a, b, low, res, vld, rdy);
      checks++;
      if (low !== LAT_LOW || vld !== 1'b1 || res !== exp_r) begin
        failures++;
        $display("FAIL rand_op[%0d] op=%0d a=%h b=%h: got low=%0d valid=%b result=%h expected %0d/1/%h", i, o, a, b, low, vld, res, LAT_LOW, exp_r);
      end
      last_res = exp_r;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divu();
    test_flush();
    test_stall_hold();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
